// File: rtl/arb_pkg.sv
// Shared constants for the round-robin mux arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned BEAT_W  = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

endpackage

// File: rtl/mux4_bus.sv
// WIDTH-bit 4:1 mux built from three 2:1 stages.
module mux4_bus #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  // sel[0] picks within each pair, sel[1] picks between pairs
  always_comb begin
    lo = sel[0] ? d1 : d0;
    hi = sel[0] ? d3 : d2;
    y  = sel[1] ? hi : lo;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 output mux,
// with valid/ready forwarding and a per-grant burst limit.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic              state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [3:0]        gnt_d;
  logic [SEL_W-1:0]  sel_d;
  logic              xfer;
  logic              last_beat;

  // First set request searching ptr+1, ptr+2, ptr+3, ptr; the last hit
  // written wins, so iterate from the farthest offset to the nearest.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [SEL_W-1:0]   p
  );
    logic [SEL_W-1:0] idx;
    rr_pick = p;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = p + SEL_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Valid only while a grant is held; gnt is all-zero outside GRANT
  always_comb begin
    out_valid = |(gnt & req);
    xfer      = out_valid & out_ready;
    last_beat = (beat_q == BEAT_W'(MAX_BURST - 1));
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    gnt_d   = gnt;
    sel_d   = sel;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          sel_d   = rr_pick(req, ptr_q);
          gnt_d   = 4'(1) << rr_pick(req, ptr_q);
          beat_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer) beat_d = beat_q + BEAT_W'(1);
        if (!req[sel] || (xfer && last_beat)) begin
          ptr_d   = sel;
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and control registers; ptr resets to 3 so source 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'b11;
      beat_q  <= '0;
      gnt     <= '0;
      sel     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
    end
  end

  mux4_bus #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .d0  (din0),
    .d1  (din1),
    .d2  (din2),
    .d3  (din3),
    .y   (out_data)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: burst-4 instance plus a burst-1 instance.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic [7:0] din0 = 8'h11, din1 = 8'h22, din2 = 8'h33, din3 = 8'h44;

  logic       rst_a, rdy_a;
  logic [3:0] req_a, gnt_a;
  logic [1:0] sel_a;
  logic       val_a;
  logic [7:0] dat_a;

  logic       rst_b, rdy_b;
  logic [3:0] req_b, gnt_b;
  logic [1:0] sel_b;
  logic       val_b;
  logic [7:0] dat_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .out_ready(rdy_a), .gnt(gnt_a), .sel(sel_a),
    .out_valid(val_a), .out_data(dat_a)
  );

  rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .out_ready(rdy_b), .gnt(gnt_b), .sel(sel_b),
    .out_valid(val_b), .out_data(dat_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [7:0] din_of(input int i);
    case (i)
      0: din_of = 8'h11;
      1: din_of = 8'h22;
      2: din_of = 8'h33;
      default: din_of = 8'h44;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] eg;
    int         n;
    logic       done;

    rst_a = 1'b1; req_a = 4'b1111; rdy_a = 1'b1;
    rst_b = 1'b1; req_b = 4'b0000; rdy_b = 1'b0;

    // reset state
    smp();
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_sel", 32'(sel_a), 32'h0);
    chk("rst_valid", 32'(val_a), 32'h0);
    chk("rst_data", 32'(dat_a), 32'h11);

    // fairness: grants 0,1,2,3,0 with 4 transfers then one bubble
    tick();
    rst_a = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      smp();
      eg = (c % 5 == 0) ? 4'b0000 : 4'b0001 << ((c / 5) % 4);
      chk($sformatf("fair_gnt_c%0d", c), 32'(gnt_a), 32'(eg));
      chk($sformatf("fair_valid_c%0d", c), 32'(val_a), 32'(eg != 4'b0000));
      if (eg != 4'b0000)
        chk($sformatf("fair_data_c%0d", c), 32'(dat_a), 32'(din_of((c / 5) % 4)));
    end

    // asynchronous reset mid-burst clears outputs without a clock edge
    #2 rst_a = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt_a), 32'h0);
    chk("arst_valid", 32'(val_a), 32'h0);
    chk("arst_sel", 32'(sel_a), 32'h0);
    tick();
    rst_a = 1'b0;
    smp();
    chk("arst_hold_gnt", 32'(gnt_a), 32'h0);
    tick();
    smp();
    chk("arst_first_gnt", 32'(gnt_a), 32'h1);

    // early drop: source 2 gives two transfers then drops
    tick();
    rst_a = 1'b1; req_a = 4'b0100; rdy_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n = 0;
    tick(); smp();
    chk("drop_gnt", 32'(gnt_a), 32'h4);
    if (val_a && rdy_a) n++;
    tick(); smp();
    if (val_a && rdy_a) n++;
    tick();
    req_a = 4'b0000;
    smp();
    chk("drop_valid_low", 32'(val_a), 32'h0);
    chk("drop_gnt_held", 32'(gnt_a), 32'h4);
    chk("drop_xfers", 32'(n), 32'd2);
    tick(); smp();
    chk("drop_release", 32'(gnt_a), 32'h0);
    // ptr=2: search order 3,0,1,2 picks source 1
    req_a = 4'b0110; rdy_a = 1'b0;
    tick(); smp();
    chk("rr_after_drop_gnt", 32'(gnt_a), 32'h2);
    chk("rr_after_drop_data", 32'(dat_a), 32'h22);
    chk("rr_after_drop_valid", 32'(val_a), 32'h1);

    // drop while stalled: no transfer, release, next search from ptr=1
    tick(); smp();
    chk("dstall_gnt_held", 32'(gnt_a), 32'h2);
    req_a = 4'b0100;
    #1;
    chk("dstall_valid", 32'(val_a), 32'h0);
    tick(); smp();
    chk("dstall_release", 32'(gnt_a), 32'h0);
    req_a = 4'b1111; rdy_a = 1'b1;
    tick(); smp();
    chk("dstall_next_gnt", 32'(gnt_a), 32'h4);

    // stall on source 3: grant and data held, then exactly 4 transfers
    tick();
    rst_a = 1'b1; req_a = 4'b1000; rdy_a = 1'b0;
    tick();
    rst_a = 1'b0;
    tick(); smp();
    chk("stall_gnt0", 32'(gnt_a), 32'h8);
    for (int i = 0; i < 5; i++) begin
      tick(); smp();
      chk($sformatf("stall_gnt_%0d", i), 32'(gnt_a), 32'h8);
      chk($sformatf("stall_data_%0d", i), 32'(dat_a), 32'h44);
    end
    rdy_a = 1'b1;
    #1;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (gnt_a !== 4'b1000) begin
        done = 1'b1;
        break;
      end
      if (val_a) n++;
      smp();
      #1;
    end
    chk("stall_released", 32'(done), 32'h1);
    chk("stall_xfers", 32'(n), 32'd4);

    // MAX_BURST=1: sources 0 and 3 alternate with a bubble between
    req_a = 4'b0000;
    req_b = 4'b1001; rdy_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick(); smp();
      eg = (c % 2 == 0) ? 4'b0000 : ((c % 4 == 1) ? 4'b0001 : 4'b1000);
      chk($sformatf("mb1_gnt_c%0d", c), 32'(gnt_b), 32'(eg));
      chk($sformatf("mb1_valid_c%0d", c), 32'(val_b), 32'(eg != 4'b0000));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
